// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
//   Write-back stage sitting directly behind the MEM stage. It owns the MEM/WB
//   pipeline register, picks the write-back value (load data, ALU result or
//   JAL link address) and drives the register-file write port, which doubles
//   as the WB forwarding source. A retiring HALT freezes write-back in the
//   HALTED state until the debug unit pulses resume.
//
// Optional feature macro: WB_RETIRE_COUNT_EN
//   defined   -> retired_count counts instructions leaving the stage in RUN
//   undefined -> no counter logic, retired_count is tied to 0
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall, flush        hold / bubble the MEM/WB register
//   valid_in .. is_halt_in   instruction fields from the MEM stage
//   resume              debug pulse that leaves HALTED
//   rf_write_en/addr/data    register-file write port (data also forwards)
//   halted              high while the stage is frozen
//   retired_count       retired-instruction counter
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [REG_AW-1:0] write_register_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic [DATA_W-1:0] pc_plus_4_in,
  input  logic              is_jal_in,
  input  logic              is_halt_in,
  input  logic              resume,
  output logic              rf_write_en,
  output logic [REG_AW-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_count
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  logic [0:0]        state_q;
  logic              valid_q;
  logic [DATA_W-1:0] read_data_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [REG_AW-1:0] write_register_q;
  logic              reg_write_q;
  logic              mem_to_reg_q;
  logic [DATA_W-1:0] pc_plus_4_q;
  logic              is_jal_q;
  logic              is_halt_q;

  logic              in_run;
  logic              entry_clear;
  logic              entry_load;

  assign in_run = (state_q == RUN);

  // Leaving HALTED discards whatever sat in the register while frozen, so the
  // first instruction after resume comes in through a normal load.
  assign entry_clear = flush | (~in_run & resume);
  assign entry_load  = in_run & ~stall;

  // RUN -> HALTED once a valid HALT has spent one cycle in WB; only resume
  // brings the stage back. A flush does not affect the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else if (in_run) begin
      if (valid_q && is_halt_q) begin
        state_q <= HALTED;
      end
    end else if (resume) begin
      state_q <= RUN;
    end
  end

  // MEM/WB register: reset > flush/resume bubble > frozen or stalled > load.
  always_ff @(posedge clk) begin
    if (reset || entry_clear) begin
      valid_q          <= 1'b0;
      read_data_q      <= '0;
      alu_result_q     <= '0;
      write_register_q <= '0;
      reg_write_q      <= 1'b0;
      mem_to_reg_q     <= 1'b0;
      pc_plus_4_q      <= '0;
      is_jal_q         <= 1'b0;
      is_halt_q        <= 1'b0;
    end else if (entry_load) begin
      valid_q          <= valid_in;
      read_data_q      <= read_data_in;
      alu_result_q     <= alu_result_in;
      write_register_q <= write_register_in;
      reg_write_q      <= reg_write_in;
      mem_to_reg_q     <= mem_to_reg_in;
      pc_plus_4_q      <= pc_plus_4_in;
      is_jal_q         <= is_jal_in;
      is_halt_q        <= is_halt_in;
    end
  end

  // The link address outranks the memory/ALU select.
  always_comb begin
    rf_write_data = alu_result_q;
    if (is_jal_q) begin
      rf_write_data = pc_plus_4_q;
    end else if (mem_to_reg_q) begin
      rf_write_data = read_data_q;
    end
  end

  // Register $0 is hardwired, so a write to it is suppressed here rather than
  // relying on the register file to ignore it.
  assign rf_write_en   = valid_q & reg_write_q & (write_register_q != '0) & in_run;
  assign rf_write_addr = write_register_q;
  assign halted        = ~in_run;

`ifdef WB_RETIRE_COUNT_EN
  logic             retire_now;
  logic [CNT_W-1:0] retired_q;

  // An entry retires when it leaves the register in RUN: on a normal load or
  // when a flush replaces it. A stall keeps it in place, so the repeated
  // write of a stalled instruction is counted once.
  assign retire_now = in_run & valid_q & (flush | ~stall);

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (retire_now) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
//   Directed bench for wb_stage. A behavioural model tracks the instruction
//   currently in write-back, the halted flag and the retire count; a compare
//   process checks every DUT output against it on each falling edge, and a
//   set of hand-computed expectations pins the model.
// ---------------------------------------------------------------------------
module tb_wb_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  logic              clk;
  logic              reset;
  logic              stall;
  logic              flush;
  logic              valid_in;
  logic [DATA_W-1:0] read_data_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [REG_AW-1:0] write_register_in;
  logic              reg_write_in;
  logic              mem_to_reg_in;
  logic [DATA_W-1:0] pc_plus_4_in;
  logic              is_jal_in;
  logic              is_halt_in;
  logic              resume;
  logic              rf_write_en;
  logic [REG_AW-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic              halted;
  logic [CNT_W-1:0]  retired_count;

  int testsRun  = 0;
  int testsFail = 0;
  bit checkEn   = 0;

  wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .flush             (flush),
    .valid_in          (valid_in),
    .read_data_in      (read_data_in),
    .alu_result_in     (alu_result_in),
    .write_register_in (write_register_in),
    .reg_write_in      (reg_write_in),
    .mem_to_reg_in     (mem_to_reg_in),
    .pc_plus_4_in      (pc_plus_4_in),
    .is_jal_in         (is_jal_in),
    .is_halt_in        (is_halt_in),
    .resume            (resume),
    .rf_write_en       (rf_write_en),
    .rf_write_addr     (rf_write_addr),
    .rf_write_data     (rf_write_data),
    .halted            (halted),
    .retired_count     (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the instruction sitting in write-back.
  typedef struct {
    bit              valid;
    bit              regWrite;
    bit              memToReg;
    bit              isJal;
    bit              isHalt;
    bit [REG_AW-1:0] wr;
    bit [DATA_W-1:0] rd;
    bit [DATA_W-1:0] alu;
    bit [DATA_W-1:0] pc;
  } instrT;

  instrT           wbInstr;
  instrT           emptyInstr;
  bit              mHalted = 0;
  bit [CNT_W-1:0]  mCount  = '0;

  function automatic bit [DATA_W-1:0] wbValue(instrT i);
    if (i.isJal)    return i.pc;
    if (i.memToReg) return i.rd;
    return i.alu;
  endfunction

  always @(posedge clk) begin
    instrT incoming;
    bit    frozen;
    incoming.valid    = valid_in;
    incoming.regWrite = reg_write_in;
    incoming.memToReg = mem_to_reg_in;
    incoming.isJal    = is_jal_in;
    incoming.isHalt   = is_halt_in;
    incoming.wr       = write_register_in;
    incoming.rd       = read_data_in;
    incoming.alu      = alu_result_in;
    incoming.pc       = pc_plus_4_in;
    frozen            = mHalted;
    if (reset) begin
      wbInstr = emptyInstr;
      mHalted = 0;
      mCount  = '0;
    end else begin
      if (!frozen && wbInstr.valid && (flush || !stall)) mCount = mCount + 1;
      if (frozen) mHalted = !resume;
      else        mHalted = wbInstr.valid && wbInstr.isHalt;
      if (flush || (frozen && resume)) wbInstr = emptyInstr;
      else if (!frozen && !stall)      wbInstr = incoming;
    end
  end

  task automatic report(string name, logic [63:0] act, logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      bit expEn;
      expEn = wbInstr.valid && wbInstr.regWrite && (wbInstr.wr != 0) && !mHalted;
      report("model_en",     64'(rf_write_en),   64'(expEn));
      report("model_addr",   64'(rf_write_addr), 64'(wbInstr.wr));
      report("model_data",   64'(rf_write_data), 64'(wbValue(wbInstr)));
      report("model_halted", 64'(halted),        64'(mHalted));
`ifdef WB_RETIRE_COUNT_EN
      report("model_count",  64'(retired_count), 64'(mCount));
`else
      report("model_count",  64'(retired_count), 64'd0);
`endif
    end
  end

  // Drive one cycle of MEM-stage inputs and wait until the falling edge after
  // the clock edge that consumed them.
  task automatic applyStimulus(bit v, bit rw, bit [REG_AW-1:0] wr, bit mtr, bit jal,
                               bit hlt, bit [DATA_W-1:0] rd, bit [DATA_W-1:0] alu,
                               bit [DATA_W-1:0] pc, bit st, bit fl, bit rs);
    valid_in          = v;
    reg_write_in      = rw;
    write_register_in = wr;
    mem_to_reg_in     = mtr;
    is_jal_in         = jal;
    is_halt_in        = hlt;
    read_data_in      = rd;
    alu_result_in     = alu;
    pc_plus_4_in      = pc;
    stall             = st;
    flush             = fl;
    resume            = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(string name, bit en, bit [REG_AW-1:0] addr,
                             bit [DATA_W-1:0] data, bit hlt);
    report({name, "_en"},     64'(rf_write_en),   64'(en));
    report({name, "_addr"},   64'(rf_write_addr), 64'(addr));
    report({name, "_data"},   64'(rf_write_data), 64'(data));
    report({name, "_halted"}, 64'(halted),        64'(hlt));
  endtask

  initial begin
    emptyInstr = '{default: 0};
    wbInstr    = emptyInstr;

    // Reset for two cycles with random inputs.
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), REG_AW'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                    1'($urandom), 1'($urandom), 1'($urandom));
      checkEn = 1;
    end
    checkOutput("reset", 0, 0, 0, 0);
    report("reset_count", 64'(retired_count), 64'd0);
    reset = 1'b0;

    // ALU, load, JAL, then a write to $0.
    applyStimulus(1, 1, 8,  0, 0, 0, 32'h1111_2222, 32'h1234, 32'h10, 0, 0, 0);
    checkOutput("alu", 1, 8, 32'h1234, 0);
    applyStimulus(1, 1, 9,  1, 0, 0, 32'hDEAD_BEEF, 32'h5555, 32'h14, 0, 0, 0);
    checkOutput("load", 1, 9, 32'hDEAD_BEEF, 0);
    applyStimulus(1, 1, 31, 1, 1, 0, 32'hCAFE_0000, 32'h6666, 32'h40, 0, 0, 0);
    checkOutput("jal", 1, 31, 32'h40, 0);
    applyStimulus(1, 1, 0,  0, 0, 0, 32'h0, 32'h55, 32'h44, 0, 0, 0);
    checkOutput("reg_zero", 0, 0, 32'h55, 0);
`ifdef WB_RETIRE_COUNT_EN
    report("count_after_four", 64'(retired_count), 64'd3);
`endif

    // Flush in the same cycle as a valid write, then a non-writing op.
    applyStimulus(1, 1, 7,  0, 0, 0, 32'h0, 32'h77, 32'h48, 0, 1, 0);
    checkOutput("flush", 0, 0, 0, 0);
    applyStimulus(1, 0, 3,  0, 0, 0, 32'h0, 32'h7777, 32'h4C, 0, 0, 0);
    checkOutput("no_write", 0, 3, 32'h7777, 0);

    // Stall holds the wr=5 instruction while new inputs keep arriving.
    applyStimulus(1, 1, 5,  0, 0, 0, 32'h0, 32'hAAAA, 32'h50, 0, 0, 0);
    checkOutput("stall_load", 1, 5, 32'hAAAA, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, REG_AW'(6 + i), 0, 0, 0, 32'h0, 32'hB000 + i, 32'h54, 1, 0, 0);
      checkOutput("stall_hold", 1, 5, 32'hAAAA, 0);
    end
    applyStimulus(0, 0, 0,  0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    checkOutput("stall_release", 0, 0, 0, 0);

    // resume while running is ignored.
    applyStimulus(1, 1, 4,  0, 0, 0, 32'h0, 32'h4444, 32'h58, 0, 0, 1);
    checkOutput("resume_in_run", 1, 4, 32'h4444, 0);

    // HALT with an ALU op behind it.
    applyStimulus(1, 0, 0,  0, 0, 1, 32'h0, 32'h0, 32'h5C, 0, 0, 0);
    checkOutput("halt_in_wb", 0, 0, 0, 0);
    applyStimulus(1, 1, 12, 0, 0, 0, 32'h0, 32'hC0DE, 32'h60, 0, 0, 0);
    checkOutput("halted", 0, 12, 32'hC0DE, 1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 13, 0, 0, 0, 32'h0, 32'hD00D, 32'h64, 0, 0, 0);
      checkOutput("halted_hold", 0, 12, 32'hC0DE, 1);
    end
    applyStimulus(1, 1, 13, 0, 0, 0, 32'h0, 32'hD00D, 32'h64, 0, 1, 0);
    checkOutput("halted_flush", 0, 0, 0, 1);
    applyStimulus(1, 1, 14, 0, 0, 0, 32'h0, 32'hE00E, 32'h68, 0, 0, 1);
    checkOutput("resume", 0, 0, 0, 0);
    applyStimulus(1, 1, 15, 0, 0, 0, 32'h0, 32'hF00D, 32'h6C, 0, 0, 0);
    checkOutput("after_resume", 1, 15, 32'hF00D, 0);

    // Reset in the middle of a stall empties the register.
    applyStimulus(1, 1, 16, 0, 0, 0, 32'h0, 32'h1616, 32'h70, 1, 0, 0);
    checkOutput("pre_reset_stall", 1, 15, 32'hF00D, 0);
    reset = 1'b1;
    applyStimulus(1, 1, 17, 0, 0, 0, 32'h0, 32'h1717, 32'h74, 1, 0, 0);
    checkOutput("reset_mid_stall", 0, 0, 0, 0);
    report("reset_mid_stall_count", 64'(retired_count), 64'd0);
    reset = 1'b0;

    // Reset while halted returns to RUN.
    applyStimulus(1, 0, 0,  0, 0, 1, 32'h0, 32'h0, 32'h78, 0, 0, 0);
    applyStimulus(0, 0, 0,  0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    checkOutput("halt_again", 0, 0, 0, 1);
    reset = 1'b1;
    applyStimulus(0, 0, 0,  0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    checkOutput("reset_mid_halt", 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(1, 1, 18, 0, 0, 0, 32'h0, 32'h1818, 32'h7C, 0, 0, 0);
    checkOutput("after_halt_reset", 1, 18, 32'h1818, 0);

    checkEn = 0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
